// File: rtl/aes_mode_engine.sv
// aes_mode_engine: ECB/CBC-encrypt/CTR mode controller around an iterative AES-128 encrypt core
module aes_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] block_in,
  output logic         valid,
  output logic [127:0] block_out
);
  logic [127:0] r_state, r_rk, w_rk_next, w_sr, w_round;
  logic [7:0]   r_rcon;
  logic [3:0]   r_round;
  logic         r_valid;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction
  // S-box from the field inverse (a^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv, sq;
    inv = 8'h01;
    sq  = a;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    return o;
  endfunction
  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction
  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  always_comb begin
    w_rk_next = next_key(r_rk, r_rcon);
    w_sr      = sub_shift(r_state);
    w_round   = (r_round == 4'd10 ? w_sr : mix(w_sr)) ^ w_rk_next;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= '0;
      r_rk    <= '0;
      r_rcon  <= '0;
      r_round <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (start) begin
        r_state <= block_in ^ key;
        r_rk    <= key;
        r_rcon  <= 8'h01;
        r_round <= 4'd1;
      end else if (r_round != 4'd0) begin
        r_state <= w_round;
        r_rk    <= w_rk_next;
        r_rcon  <= xt(r_rcon);
        r_round <= r_round == 4'd10 ? 4'd0 : r_round + 4'd1;
        r_valid <= r_round == 4'd10;
      end
    end
  end
  assign valid     = r_valid;
  assign block_out = r_state;
endmodule

module aes_mode_engine #(
  parameter int CTR_WIDTH = 32,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [1:0]       i_cfg_mode,
  input  logic [127:0]     i_cfg_key,
  input  logic [127:0]     i_cfg_iv,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [127:0]     i_in_data,
  input  logic             i_in_last,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [127:0]     o_out_data,
  output logic             o_out_last,
  output logic             o_busy,
  output logic             o_cfg_err,
  output logic [CNT_W-1:0] o_blk_count
);
  typedef enum logic [2:0] {IDLE, WAIT_IN, START, CRYPT, HOLD} state_t;
  localparam logic [127:0] CTR_MASK = {128{1'b1}} >> (128 - CTR_WIDTH);
  state_t r_state, w_next;
  logic [127:0] r_key, r_chain, r_ctr, r_data, r_out, w_block_in, w_core_out, w_ctr_inc;
  logic [1:0] r_mode;
  logic r_last, r_out_last, r_cfg_err, w_core_valid;
  logic [CNT_W-1:0] r_count;
  aes_core u_core (
    .clk      (clk),
    .rst_n    (~rst),
    .start    (r_state == START),
    .key      (r_key),
    .block_in (w_block_in),
    .valid    (w_core_valid),
    .block_out(w_core_out)
  );
  assign w_block_in = r_mode == 2'd2 ? r_ctr : r_mode == 2'd1 ? r_data ^ r_chain : r_data;
  // only the low CTR_WIDTH bits count; the upper nonce bits are preserved
  assign w_ctr_inc = (r_ctr & ~CTR_MASK) | ((r_ctr + 128'd1) & CTR_MASK);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = i_cfg_valid && i_cfg_mode != 2'd3 ? WAIT_IN : IDLE;
      WAIT_IN: w_next = i_in_valid ? START : WAIT_IN;
      START:   w_next = CRYPT;
      CRYPT:   w_next = w_core_valid ? HOLD : CRYPT;
      HOLD:    w_next = i_out_ready ? (r_out_last ? IDLE : WAIT_IN) : HOLD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_key      <= '0;
      r_mode     <= '0;
      r_chain    <= '0;
      r_ctr      <= '0;
      r_data     <= '0;
      r_last     <= 1'b0;
      r_out      <= '0;
      r_out_last <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && i_cfg_valid) begin
        r_key     <= i_cfg_key;
        r_mode    <= i_cfg_mode;
        r_chain   <= i_cfg_iv;
        r_ctr     <= i_cfg_iv;
        r_count   <= '0;
        r_cfg_err <= i_cfg_mode == 2'd3;
      end
      if (r_state == WAIT_IN && i_in_valid) begin
        r_data <= i_in_data;
        r_last <= i_in_last;
      end
      if (r_state == CRYPT && w_core_valid) begin
        r_out      <= r_mode == 2'd2 ? w_core_out ^ r_data : w_core_out;
        r_out_last <= r_last;
        if (r_mode == 2'd1) r_chain <= w_core_out;
        if (r_mode == 2'd2) r_ctr <= w_ctr_inc;
      end
      if (r_state == HOLD && i_out_ready && !(&r_count)) r_count <= r_count + CNT_W'(1);
    end
  end
  assign o_cfg_ready = r_state == IDLE;
  assign o_in_ready  = r_state == WAIT_IN;
  assign o_out_valid = r_state == HOLD;
  assign o_busy      = r_state != IDLE;
  assign o_out_data  = r_out;
  assign o_out_last  = r_out_last;
  assign o_cfg_err   = r_cfg_err;
  assign o_blk_count = r_count;
endmodule
